// File: rtl/vga_timing_if.sv
// ============================================================================
// Module   : vga_timing_if
// Brief    : VGA timing bundle: counters, syncs, display flags, image address.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_if;
    logic [11:0] H_counter;
    logic [9:0]  V_counter;
    logic        HSYNC;
    logic        VSYNC;
    logic        H_pixel_disp;
    logic        V_pixel_disp;
    logic [13:0] pixel_addr;
    logic        frame_start;

    modport master (
        output H_counter, V_counter, HSYNC, VSYNC,
               H_pixel_disp, V_pixel_disp, pixel_addr, frame_start
    );

    modport slave (
        input  H_counter, V_counter, HSYNC, VSYNC,
               H_pixel_disp, V_pixel_disp, pixel_addr, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_generator.sv
// ============================================================================
// Module   : vga_timing_generator
// Brief    : Free-running 640x480@60 VGA timing with 128x96 frame-buffer address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_generator #(
    parameter int H_DISP        = 2560,
    parameter int H_FP          = 64,
    parameter int H_SYNC        = 384,
    parameter int H_BP          = 192,
    parameter int V_DISP        = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 29,
    parameter int CLK_PER_COL   = 20,
    parameter int LINES_PER_ROW = 5
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int COLS    = H_DISP / CLK_PER_COL;
    localparam int ROWS    = V_DISP / LINES_PER_ROW;
    localparam int SUB_W   = (CLK_PER_COL > 1)   ? $clog2(CLK_PER_COL)   : 1;
    localparam int REP_W   = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

    localparam logic [11:0]      H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0]      H_DISP_END = 12'(H_DISP);
    localparam logic [11:0]      HS_START   = 12'(H_DISP + H_FP);
    localparam logic [11:0]      HS_END     = 12'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_DISP_END = 10'(V_DISP);
    localparam logic [9:0]       VS_START   = 10'(V_DISP + V_FP);
    localparam logic [9:0]       VS_END     = 10'(V_DISP + V_FP + V_SYNC);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CLK_PER_COL - 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(LINES_PER_ROW - 1);
    localparam logic [6:0]       COL_LAST   = 7'(COLS - 1);
    localparam logic [6:0]       ROW_LAST   = 7'(ROWS - 1);

    logic [11:0]      h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [6:0]       col_q, col_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [6:0]       row_q, row_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hdisp_q, hdisp_d;
    logic             vdisp_q, vdisp_d;
    logic [13:0]      addr_q, addr_d;
    logic             fs_q, fs_d;
    logic             h_wrap;
    logic             v_wrap;

    // Counter next-state; col/sub and row/repeat step only inside the display window
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_wrap ? 12'd0 : h_q + 12'd1;
        v_d    = v_q;
        sub_d  = sub_q;
        col_d  = col_q;
        rep_d  = rep_q;
        row_d  = row_q;

        if (h_wrap) begin
            v_d   = v_wrap ? 10'd0 : v_q + 10'd1;
            sub_d = '0;
            col_d = '0;
        end else if (hdisp_q) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                col_d = (col_q == COL_LAST) ? 7'd0 : col_q + 7'd1;
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end

        if (h_wrap) begin
            if (v_wrap) begin
                rep_d = '0;
                row_d = '0;
            end else if (vdisp_q) begin
                if (rep_q == REP_LAST) begin
                    rep_d = '0;
                    row_d = (row_q == ROW_LAST) ? 7'd0 : row_q + 7'd1;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
        end
    end

    // Outputs decode the next-state counters so they move on the same edge
    always_comb begin
        hsync_d = !((h_d >= HS_START) && (h_d < HS_END));
        vsync_d = !((v_d >= VS_START) && (v_d < VS_END));
        hdisp_d = (h_d < H_DISP_END);
        vdisp_d = (v_d < V_DISP_END);
        addr_d  = {row_d, col_d};
        fs_d    = (h_d == H_LAST) && (v_d == V_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            sub_q   <= '0;
            col_q   <= '0;
            rep_q   <= '0;
            row_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            hdisp_q <= 1'b1;
            vdisp_q <= 1'b1;
            addr_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            sub_q   <= sub_d;
            col_q   <= col_d;
            rep_q   <= rep_d;
            row_q   <= row_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hdisp_q <= hdisp_d;
            vdisp_q <= vdisp_d;
            addr_q  <= addr_d;
            fs_q    <= fs_d;
        end
    end

    assign vga.H_counter    = h_q;
    assign vga.V_counter    = v_q;
    assign vga.HSYNC        = hsync_q;
    assign vga.VSYNC        = vsync_q;
    assign vga.H_pixel_disp = hdisp_q;
    assign vga.V_pixel_disp = vdisp_q;
    assign vga.pixel_addr   = addr_q;
    assign vga.frame_start  = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
// ============================================================================
// Module   : tb_vga_timing_generator
// Brief    : Directed checks on full-size timing plus a scaled frame instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rst_f;
    logic rst_s;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_if vif_f ();
    vga_timing_if vif_s ();

    vga_timing_generator u_full (
        .clk   (clk),
        .reset (rst_f),
        .vga   (vif_f)
    );

    // Scaled instance: 144 clocks/line, 103 lines/frame, one clock per column, one line per row
    vga_timing_generator #(
        .H_DISP(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_DISP(96),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_PER_COL(1), .LINES_PER_ROW(1)
    ) u_small (
        .clk   (clk),
        .reset (rst_s),
        .vga   (vif_s)
    );

    task automatic step_full(input int h, input int v, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (vif_f.H_counter == 12'(h) && vif_f.V_counter == 10'(v)) found = 1'b1;
        end
    endtask

    task automatic step_small(input int h, input int v, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (vif_s.H_counter == 12'(h) && vif_s.V_counter == 10'(v)) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_f = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (vif_f.H_counter !== 12'd0) begin errors++; $display("FAIL reset_H got %0d want 0", vif_f.H_counter); end
        checks++; if (vif_f.V_counter !== 10'd0) begin errors++; $display("FAIL reset_V got %0d want 0", vif_f.V_counter); end
        checks++; if (vif_f.HSYNC !== 1'b1) begin errors++; $display("FAIL reset_HSYNC got %b want 1", vif_f.HSYNC); end
        checks++; if (vif_f.VSYNC !== 1'b1) begin errors++; $display("FAIL reset_VSYNC got %b want 1", vif_f.VSYNC); end
        checks++; if (vif_f.H_pixel_disp !== 1'b1) begin errors++; $display("FAIL reset_Hdisp got %b want 1", vif_f.H_pixel_disp); end
        checks++; if (vif_f.V_pixel_disp !== 1'b1) begin errors++; $display("FAIL reset_Vdisp got %b want 1", vif_f.V_pixel_disp); end
        checks++; if (vif_f.pixel_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", vif_f.pixel_addr); end
        checks++; if (vif_f.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", vif_f.frame_start); end
        rst_f = 1'b0;
        @(negedge clk);
        checks++;
        if (vif_f.H_counter !== 12'd1 || vif_f.V_counter !== 10'd0) begin
            errors++;
            $display("FAIL first_edge got H=%0d V=%0d want H=1 V=0", vif_f.H_counter, vif_f.V_counter);
        end
    endtask

    // Continues from H=1 of line 0 through H=1 of line 1
    task automatic test_line_sweep;
        int          hs_low = 0;
        int          hd_high = 0;
        logic [11:0] eh;
        logic [9:0]  ev;
        logic [13:0] ea;
        logic        ehs, ehd;
        for (int k = 2; k <= 3201; k++) begin
            @(negedge clk);
            eh  = 12'(k % 3200);
            ev  = (k >= 3200) ? 10'd1 : 10'd0;
            ehs = !((eh >= 12'd2624) && (eh < 12'd3008));
            ehd = (eh < 12'd2560);
            ea  = ehd ? 14'(eh / 12'd20) : 14'd0;
            checks++;
            if ({vif_f.H_counter, vif_f.V_counter, vif_f.HSYNC, vif_f.VSYNC, vif_f.H_pixel_disp,
                 vif_f.V_pixel_disp, vif_f.pixel_addr, vif_f.frame_start}
                !== {eh, ev, ehs, 1'b1, ehd, 1'b1, ea, 1'b0}) begin
                errors++;
                $display("FAIL line_sweep k=%0d got H=%0d V=%0d hs=%b vs=%b hd=%b vd=%b addr=%0d fs=%b want H=%0d V=%0d hs=%b vs=1 hd=%b vd=1 addr=%0d fs=0",
                         k, vif_f.H_counter, vif_f.V_counter, vif_f.HSYNC, vif_f.VSYNC, vif_f.H_pixel_disp,
                         vif_f.V_pixel_disp, vif_f.pixel_addr, vif_f.frame_start, eh, ev, ehs, ehd, ea);
            end
            if (!vif_f.HSYNC) hs_low++;
            if (vif_f.H_pixel_disp) hd_high++;
            if (k == 20) begin
                checks++; if (vif_f.pixel_addr !== 14'd1) begin errors++; $display("FAIL addr_H20 got %0d want 1", vif_f.pixel_addr); end
            end
            if (k == 2559) begin
                checks++; if (vif_f.pixel_addr !== 14'd127) begin errors++; $display("FAIL addr_H2559 got %0d want 127", vif_f.pixel_addr); end
            end
            if (k == 3199) begin
                checks++; if (vif_f.H_counter !== 12'd3199) begin errors++; $display("FAIL h_last got %0d want 3199", vif_f.H_counter); end
            end
            if (k == 3200) begin
                checks++;
                if (vif_f.H_counter !== 12'd0 || vif_f.V_counter !== 10'd1) begin
                    errors++;
                    $display("FAIL line_wrap got H=%0d V=%0d want H=0 V=1", vif_f.H_counter, vif_f.V_counter);
                end
            end
        end
        checks++; if (hs_low != 384) begin errors++; $display("FAIL hsync_width got %0d want 384", hs_low); end
        checks++; if (hd_high != 2560) begin errors++; $display("FAIL hdisp_width got %0d want 2560", hd_high); end
    endtask

    task automatic test_rows;
        bit found;
        step_full(100, 4, 12000, found);
        checks++;
        if (!found) begin errors++; $display("FAIL rows_timeout_V4 got not_reached want reached"); end
        else begin
            checks++; if (vif_f.pixel_addr !== 14'd5) begin errors++; $display("FAIL addr_V4_H100 got %0d want 5", vif_f.pixel_addr); end
        end
        step_full(0, 5, 4000, found);
        checks++;
        if (!found) begin errors++; $display("FAIL rows_timeout_V5 got not_reached want reached"); end
        else begin
            checks++; if (vif_f.pixel_addr !== 14'd128) begin errors++; $display("FAIL addr_V5_H0 got %0d want 128", vif_f.pixel_addr); end
        end
        step_full(20, 5, 40, found);
        checks++;
        if (!found) begin errors++; $display("FAIL rows_timeout_V5H20 got not_reached want reached"); end
        else begin
            checks++; if (vif_f.pixel_addr !== 14'd129) begin errors++; $display("FAIL addr_V5_H20 got %0d want 129", vif_f.pixel_addr); end
        end
    endtask

    // Two complete frames of the scaled instance, every clock compared
    task automatic test_frame_sweep;
        int eh = 0, ev = 0;
        int pulses = 0, vs_low = 0, fs1 = -1, fs2 = -1;
        logic ehs, evs, ehd, evd, efs;
        logic [13:0] ea;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.H_pixel_disp,
             vif_s.V_pixel_disp, vif_s.pixel_addr, vif_s.frame_start} !== {12'd0, 10'd0, 4'b1111, 14'd0, 1'b0}) begin
            errors++;
            $display("FAIL small_reset got H=%0d V=%0d addr=%0d want H=0 V=0 addr=0", vif_s.H_counter, vif_s.V_counter, vif_s.pixel_addr);
        end
        rst_s = 1'b0;
        for (int cyc = 1; cyc <= 2 * 14832; cyc++) begin
            @(negedge clk);
            eh++;
            if (eh == 144) begin
                eh = 0;
                ev++;
                if (ev == 103) ev = 0;
            end
            ehs = !(eh >= 132 && eh < 140);
            evs = !(ev >= 98 && ev < 100);
            ehd = (eh < 128);
            evd = (ev < 96);
            ea  = 14'((evd ? ev * 128 : 0) + (ehd ? eh : 0));
            efs = (eh == 143 && ev == 102);
            checks++;
            if ({vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.H_pixel_disp,
                 vif_s.V_pixel_disp, vif_s.pixel_addr, vif_s.frame_start}
                !== {12'(eh), 10'(ev), ehs, evs, ehd, evd, ea, efs}) begin
                errors++;
                $display("FAIL frame_sweep cyc=%0d got H=%0d V=%0d hs=%b vs=%b hd=%b vd=%b addr=%0d fs=%b want H=%0d V=%0d hs=%b vs=%b hd=%b vd=%b addr=%0d fs=%b",
                         cyc, vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.H_pixel_disp,
                         vif_s.V_pixel_disp, vif_s.pixel_addr, vif_s.frame_start, eh, ev, ehs, evs, ehd, evd, ea, efs);
            end
            if (!vif_s.VSYNC && cyc <= 14832) vs_low++;
            if (vif_s.frame_start === 1'b1) begin
                pulses++;
                if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
            end
            if (eh == 127 && ev == 95) begin
                checks++; if (vif_s.pixel_addr !== 14'd12287) begin errors++; $display("FAIL addr_last got %0d want 12287", vif_s.pixel_addr); end
            end
            if (eh == 0 && ev == 96) begin
                checks++;
                if (vif_s.V_pixel_disp !== 1'b0 || vif_s.pixel_addr !== 14'd0) begin
                    errors++;
                    $display("FAIL vblank_entry got vd=%b addr=%0d want vd=0 addr=0", vif_s.V_pixel_disp, vif_s.pixel_addr);
                end
            end
            if (cyc == 14832) begin
                checks++; if (vs_low != 288) begin errors++; $display("FAIL vsync_width got %0d want 288", vs_low); end
                checks++; if (pulses != 1) begin errors++; $display("FAIL fs_per_frame got %0d want 1", pulses); end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL fs_two_frames got %0d want 2", pulses); end
        checks++; if (fs2 - fs1 != 14832) begin errors++; $display("FAIL fs_spacing got %0d want 14832", fs2 - fs1); end
    endtask

    task automatic test_async_reset;
        bit found;
        int eh = 0, ev = 0, hs_low = 0;
        logic ehs;
        step_small(70, 50, 16000, found);
        checks++;
        if (!found) begin errors++; $display("FAIL async_timeout got not_reached want reached"); end
        #2 rst_s = 1'b1;
        #1;
        checks++;
        if ({vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.H_pixel_disp,
             vif_s.V_pixel_disp, vif_s.pixel_addr, vif_s.frame_start} !== {12'd0, 10'd0, 4'b1111, 14'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got H=%0d V=%0d hs=%b vs=%b addr=%0d want H=0 V=0 hs=1 vs=1 addr=0",
                     vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.pixel_addr);
        end
        @(negedge clk);
        checks++; if (vif_s.H_counter !== 12'd0) begin errors++; $display("FAIL reset_hold got H=%0d want 0", vif_s.H_counter); end
        rst_s = 1'b0;
        for (int cyc = 1; cyc <= 4 * 144; cyc++) begin
            @(negedge clk);
            eh++;
            if (eh == 144) begin eh = 0; ev++; end
            ehs = !(eh >= 132 && eh < 140);
            checks++;
            if ({vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.pixel_addr}
                !== {12'(eh), 10'(ev), ehs, 1'b1, 14'(ev * 128 + (eh < 128 ? eh : 0))}) begin
                errors++;
                $display("FAIL restart cyc=%0d got H=%0d V=%0d hs=%b vs=%b addr=%0d want H=%0d V=%0d hs=%b vs=1",
                         cyc, vif_s.H_counter, vif_s.V_counter, vif_s.HSYNC, vif_s.VSYNC, vif_s.pixel_addr, eh, ev, ehs);
            end
            if (!vif_s.HSYNC) hs_low++;
        end
        checks++; if (hs_low != 32) begin errors++; $display("FAIL restart_hsync got %0d want 32", hs_low); end
    endtask

    initial begin
        rst_f = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_line_sweep();
        test_rows();
        rst_f = 1'b1;
        test_frame_sweep();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
